// File: rtl/regbank_mailbox_if.sv
// Register-bus bundle for one processor side of the mailbox bank.
// The master drives requests; the slave returns acknowledge, read data and irq.
interface regbank_mailbox_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              bus_enable;
    logic              rw;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              acknowledge;
    logic [DATA_W-1:0] read_data;
    logic              irq;

    modport master (
        output bus_enable, rw, address, write_data,
        input  acknowledge, read_data, irq
    );

    modport slave (
        input  bus_enable, rw, address, write_data,
        output acknowledge, read_data, irq
    );
endinterface

// File: rtl/regbank_mailbox.sv
// Dual-master mailbox register bank: NUM_MBOX words per direction, each with a
// doorbell pending bit, an irq enable and an overrun flag. Side 0 = HPS, side 1 = NIOS.
module regbank_mailbox #(
    parameter int DATA_W   = 32,
    parameter int NUM_MBOX = 4,
    parameter int ADDR_W   = 4
) (
    input logic               clk,
    input logic               rst,
    regbank_mailbox_if.slave  hr_if,
    regbank_mailbox_if.slave  nr_if
);

    logic              en    [2];
    logic              rw    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];

    logic [NUM_MBOX-1:0] pend_q   [2];
    logic [NUM_MBOX-1:0] pend_d   [2];
    logic [NUM_MBOX-1:0] ovr_q    [2];
    logic [NUM_MBOX-1:0] ovr_d    [2];
    logic [NUM_MBOX-1:0] irq_en_q [2];
    logic [NUM_MBOX-1:0] irq_en_d [2];
    logic                ack_q    [2];
    logic                ack_d    [2];
    logic                irq_q    [2];
    logic                irq_d    [2];
    logic [DATA_W-1:0]   rdata_q  [2];
    logic [DATA_W-1:0]   rdata_d  [2];
    logic [DATA_W-1:0]   mbox_q   [2][NUM_MBOX];
    logic [DATA_W-1:0]   mbox_d   [2][NUM_MBOX];
    logic [NUM_MBOX-1:0] wr_out   [2];

    assign en[0]    = hr_if.bus_enable;
    assign rw[0]    = hr_if.rw;
    assign addr[0]  = hr_if.address;
    assign wdata[0] = hr_if.write_data;
    assign en[1]    = nr_if.bus_enable;
    assign rw[1]    = nr_if.rw;
    assign addr[1]  = nr_if.address;
    assign wdata[1] = nr_if.write_data;

    assign hr_if.acknowledge = ack_q[0];
    assign hr_if.read_data   = rdata_q[0];
    assign hr_if.irq         = irq_q[0];
    assign nr_if.acknowledge = ack_q[1];
    assign nr_if.read_data   = rdata_q[1];
    assign nr_if.irq         = irq_q[1];

    for (genvar s = 0; s < 2; s++) begin : g_side
        localparam int O = 1 - s;

        logic                acc;
        logic                wr;
        logic                rd;
        logic                wr_irq_en;
        logic                wr_clr;
        logic [NUM_MBOX-1:0] wr_out_l;
        logic [DATA_W-1:0]   rmux;
        logic [NUM_MBOX-1:0] clr_pend;
        logic [NUM_MBOX-1:0] clr_ovr;

        always_comb begin
            acc       = en[s] && !ack_q[s];
            wr        = acc && !rw[s];
            rd        = acc && rw[s];
            wr_irq_en = wr && (addr[s] == ADDR_W'(1));
            wr_clr    = wr && (addr[s] == ADDR_W'(2));
            wr_out_l  = '0;
            rmux      = '0;
            if (addr[s] == ADDR_W'(0)) begin
                rmux[NUM_MBOX-1:0]  = pend_q[s];
                rmux[16 +: NUM_MBOX] = ovr_q[s];
            end else if (addr[s] == ADDR_W'(1)) begin
                rmux[NUM_MBOX-1:0] = irq_en_q[s];
            end
            // OUT[k] sits at 4+k, the peer's OUT[k] is visible as IN[k] at 4+NUM_MBOX+k
            for (int k = 0; k < NUM_MBOX; k++) begin
                if (int'(addr[s]) == 4 + k) begin
                    wr_out_l[k] = wr;
                    rmux        = mbox_q[s][k];
                end
                if (int'(addr[s]) == 4 + NUM_MBOX + k) begin
                    rmux = mbox_q[O][k];
                end
            end
            clr_pend = wr_clr ? wdata[s][NUM_MBOX-1:0]  : '0;
            clr_ovr  = wr_clr ? wdata[s][16 +: NUM_MBOX] : '0;
        end

        assign wr_out[s] = wr_out_l;

        // A doorbell set from the peer wins over a concurrent clear; overrun looks at the pre-edge pending.
        assign pend_d[s]   = (pend_q[s] & ~clr_pend) | wr_out[O];
        assign ovr_d[s]    = (ovr_q[s] & ~clr_ovr) | (wr_out[O] & pend_q[s]);
        assign irq_en_d[s] = wr_irq_en ? wdata[s][NUM_MBOX-1:0] : irq_en_q[s];
        assign ack_d[s]    = acc;
        assign rdata_d[s]  = rd ? rmux : rdata_q[s];
        assign irq_d[s]    = |(pend_q[s] & irq_en_q[s]);

        for (genvar k = 0; k < NUM_MBOX; k++) begin : g_mbox
            assign mbox_d[s][k] = wr_out_l[k] ? wdata[s] : mbox_q[s][k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                pend_q[s]   <= '0;
                ovr_q[s]    <= '0;
                irq_en_q[s] <= '0;
                ack_q[s]    <= 1'b0;
                irq_q[s]    <= 1'b0;
                rdata_q[s]  <= '0;
                for (int k = 0; k < NUM_MBOX; k++) begin
                    mbox_q[s][k] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                pend_q[s]   <= pend_d[s];
                ovr_q[s]    <= ovr_d[s];
                irq_en_q[s] <= irq_en_d[s];
                ack_q[s]    <= ack_d[s];
                irq_q[s]    <= irq_d[s];
                rdata_q[s]  <= rdata_d[s];
                for (int k = 0; k < NUM_MBOX; k++) begin
                    mbox_q[s][k] <= mbox_d[s][k];
                end
            end
        end
    end

endmodule

// File: tb/tb_regbank_mailbox.sv
// Bench for regbank_mailbox: three instances (NUM_MBOX = 4, 1, 16) share one stimulus;
// the selected instance is checked against an abstract mailbox model.
module tb_regbank_mailbox;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  [2] = '{1'b0, 1'b0};
    logic        rw  [2] = '{1'b0, 1'b0};
    logic [5:0]  ad  [2] = '{6'd0, 6'd0};
    logic [31:0] wd  [2] = '{32'd0, 32'd0};

    logic        ack_o [3][2];
    logic [31:0] rd_o  [3][2];
    logic        irq_o [3][2];

    always #10 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        localparam int NM = (d == 0) ? 4 : ((d == 1) ? 1 : 16);
        regbank_mailbox_if #(.DATA_W(32), .ADDR_W(6)) hr_if ();
        regbank_mailbox_if #(.DATA_W(32), .ADDR_W(6)) nr_if ();
        assign hr_if.bus_enable = en[0];
        assign hr_if.rw         = rw[0];
        assign hr_if.address    = ad[0];
        assign hr_if.write_data = wd[0];
        assign nr_if.bus_enable = en[1];
        assign nr_if.rw         = rw[1];
        assign nr_if.address    = ad[1];
        assign nr_if.write_data = wd[1];
        assign ack_o[d][0] = hr_if.acknowledge;
        assign rd_o[d][0]  = hr_if.read_data;
        assign irq_o[d][0] = hr_if.irq;
        assign ack_o[d][1] = nr_if.acknowledge;
        assign rd_o[d][1]  = nr_if.read_data;
        assign irq_o[d][1] = nr_if.irq;
        regbank_mailbox #(.DATA_W(32), .NUM_MBOX(NM), .ADDR_W(6)) dut (
            .clk   (clk),
            .rst   (rst),
            .hr_if (hr_if),
            .nr_if (nr_if)
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cur    = 0;
    int nm     = 4;

    // model: box[s][k] = side s outbound word k; pend/ovr[s] = flags seen by side s
    logic [31:0] m_box  [2][16];
    logic [15:0] m_pend [2];
    logic [15:0] m_ovr  [2];
    logic [15:0] m_ien  [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut=%0d got=%h exp=%h @%0t", tag, cur, got, exp, $time);
    endtask

    function automatic logic [15:0] msk();
        return 16'((32'h1 << nm) - 1);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            m_pend[s] = '0; m_ovr[s] = '0; m_ien[s] = '0;
            m_rd[s] = '0; m_irq[s] = 1'b0;
            for (int k = 0; k < 16; k++) m_box[s][k] = '0;
        end
    endtask

    function automatic logic [31:0] m_read(input int s, input int a);
        if (a == 0) return {m_ovr[s], m_pend[s]};
        if (a == 1) return {16'h0, m_ien[s]};
        if (a >= 4 && a < 4 + nm) return m_box[s][a-4];
        if (a >= 4 + nm && a < 4 + 2*nm) return m_box[1-s][a-4-nm];
        return 32'h0;
    endfunction

    // One access slot: access edge then idle edge. Entered and left at a negedge.
    task automatic step(input bit e0, input bit r0, input int a0, input logic [31:0] d0,
                        input bit e1, input bit r1, input int a1, input logic [31:0] d1);
        bit          e [2];
        bit          r [2];
        int          a [2];
        logic [31:0] d [2];
        logic [15:0] setp [2];
        logic [15:0] np [2];
        logic [15:0] no [2];
        e = '{e0, e1}; r = '{r0, r1}; a = '{a0, a1}; d = '{d0, d1};
        for (int s = 0; s < 2; s++) begin
            en[s] = e[s]; rw[s] = r[s]; ad[s] = 6'(a[s]); wd[s] = d[s];
        end
        for (int s = 0; s < 2; s++) begin
            setp[s] = '0;
            if (e[1-s] && !r[1-s] && a[1-s] >= 4 && a[1-s] < 4 + nm) setp[s][a[1-s]-4] = 1'b1;
        end
        for (int s = 0; s < 2; s++) begin
            m_irq[s] = |(m_pend[s] & m_ien[s]);
            if (e[s] && r[s]) m_rd[s] = m_read(s, a[s]);
            np[s] = m_pend[s] | setp[s];
            no[s] = m_ovr[s] | (setp[s] & m_pend[s]);
            if (e[s] && !r[s] && a[s] == 2) begin
                np[s] = (m_pend[s] & ~(d[s][15:0] & msk())) | setp[s];
                no[s] = (m_ovr[s] & ~(d[s][31:16] & msk())) | (setp[s] & m_pend[s]);
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (e[s] && !r[s] && a[s] == 1) m_ien[s] = d[s][15:0] & msk();
            if (e[s] && !r[s] && a[s] >= 4 && a[s] < 4 + nm) m_box[s][a[s]-4] = d[s];
            m_pend[s] = np[s];
            m_ovr[s]  = no[s];
        end
        @(posedge clk);
        @(negedge clk);
        en[0] = 1'b0; en[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("ack_hi s%0d", s), 32'(ack_o[cur][s]), 32'(e[s]));
            chk($sformatf("rdata s%0d a%0d", s, a[s]), rd_o[cur][s], m_rd[s]);
            chk($sformatf("irq_acc s%0d", s), 32'(irq_o[cur][s]), 32'(m_irq[s]));
        end
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            m_irq[s] = |(m_pend[s] & m_ien[s]);
            chk($sformatf("ack_lo s%0d", s), 32'(ack_o[cur][s]), 32'h0);
            chk($sformatf("rdata_hold s%0d", s), rd_o[cur][s], m_rd[s]);
            chk($sformatf("irq_idle s%0d", s), 32'(irq_o[cur][s]), 32'(m_irq[s]));
        end
    endtask

    task automatic hw(input int a, input logic [31:0] d); step(1, 0, a, d, 0, 0, 0, 0); endtask
    task automatic nw(input int a, input logic [31:0] d); step(0, 0, 0, 0, 1, 0, a, d); endtask
    task automatic nrd(input int a);                     step(0, 0, 0, 0, 1, 1, a, 0); endtask

    task automatic do_reset();
        rst = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_ack s%0d", s), 32'(ack_o[cur][s]), 32'h0);
            chk($sformatf("rst_rd s%0d", s), rd_o[cur][s], 32'h0);
            chk($sformatf("rst_irq s%0d", s), 32'(irq_o[cur][s]), 32'h0);
        end
        model_clear();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic random_phase(input int n);
        bit          e [2];
        bit          r [2];
        int          a [2];
        logic [31:0] d [2];
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < 2; s++) begin
                e[s] = ($urandom_range(0, 3) != 0);
                r[s] = 1'($urandom_range(0, 1));
                a[s] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                   : int'($urandom_range(0, 4 + 2*nm - 1));
                d[s] = $urandom;
            end
            step(e[0], r[0], a[0], d[0], e[1], r[1], a[1], d[1]);
        end
    endtask

    initial begin
        int acks;
        bit prev;
        bit consec;
        model_clear();
        repeat (2) @(negedge clk);
        cur = 0; nm = 4;
        do_reset();

        // reset contents on both sides
        for (int a = 0; a < 12; a++) step(1, 1, a, 0, 1, 1, a, 0);

        // doorbell
        nw(1, 32'h1);
        hw(4, 32'hDEADBEEF);
        chk("doorbell irq", 32'(irq_o[0][1]), 32'h1);
        nrd(0);
        chk("doorbell status", rd_o[0][1], 32'h1);
        nrd(8);
        chk("doorbell in0", rd_o[0][1], 32'hDEADBEEF);
        nw(2, 32'h1);
        chk("doorbell irq clr", 32'(irq_o[0][1]), 32'h0);

        // overrun
        hw(6, 32'h1);
        hw(6, 32'h2);
        nrd(0);
        chk("overrun status", rd_o[0][1], 32'h00040004);
        nrd(10);
        chk("overrun in2", rd_o[0][1], 32'h2);
        nw(2, 32'h00040004);
        nrd(0);
        chk("overrun cleared", rd_o[0][1], 32'h0);

        // set and clear of pending[1] in the same cycle
        hw(5, 32'h11);
        step(1, 0, 5, 32'h22, 1, 0, 2, 32'h2);
        nrd(0);
        chk("collision status", rd_o[0][1], 32'h00020002);

        // read of IN[3] concurrent with the peer writing OUT[3] sees the old word
        hw(7, 32'hA);
        step(1, 0, 7, 32'hB, 1, 1, 11, 0);
        chk("rd before wr", rd_o[0][1], 32'hA);

        // held enable on an out-of-range read
        en[0] = 1'b1; rw[0] = 1'b1; ad[0] = 6'd15;
        acks = 0; prev = 1'b0; consec = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_o[0][0]) begin
                acks++;
                if (prev) consec = 1'b1;
            end
            prev = ack_o[0][0];
        end
        en[0] = 1'b0;
        m_rd[0] = 32'h0;
        chk("hs ack count", 32'(acks), 32'd3);
        chk("hs back to back", 32'(consec), 32'h0);
        chk("hs oor read", rd_o[0][0], 32'h0);
        @(posedge clk);
        @(negedge clk);

        // reset while an access is acknowledged clears everything at once
        en[0] = 1'b1; rw[0] = 1'b0; ad[0] = 6'd4; wd[0] = 32'h55;
        @(posedge clk);
        #2;
        chk("pre-reset ack", 32'(ack_o[0][0]), 32'h1);
        rst = 1'b0;
        #1;
        chk("async reset ack", 32'(ack_o[0][0]), 32'h0);
        en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        nrd(8);
        chk("reset cleared in0", rd_o[0][1], 32'h0);

        random_phase(200);

        // parameter sweep: last channel and unimplemented high bits
        for (int d = 1; d < 3; d++) begin
            cur = d;
            nm  = (d == 1) ? 1 : 16;
            do_reset();
            hw(4 + nm - 1, 32'hC0DE0000 + 32'(nm));
            nrd(4 + 2*nm - 1);
            chk("sweep last in", rd_o[cur][1], 32'hC0DE0000 + 32'(nm));
            nrd(0);
            chk("sweep status", rd_o[cur][1], 32'h1 << (nm - 1));
            nw(1, 32'hFFFFFFFF);
            nrd(1);
            chk("sweep irq_en bits", rd_o[cur][1], 32'(msk()));
            random_phase(150);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
